// File: rtl/button_debounce.sv
// Push-button input stage: two-flop synchronizer, stable-time debounce FSM,
// registered level plus press/release/long-press pulses and a press counter.
// Long-press detection is built only when BUTTON_DEBOUNCE_LONG_PRESS_EN is defined.
module button_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'h1234,
  parameter logic [15:0] LONG_PRESS_CYCLES = 16'h8000
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press,
  output logic [7:0] press_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_e;

  localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

  state_e      state_q, state_d;
  logic        sync1_q, btn_sync_q;
  logic [15:0] db_cnt_q, db_cnt_d;
  logic        db_clr, db_inc;
  logic        press_evt, release_evt;

  logic        btn_level_q, btn_level_d;
  logic        press_pulse_q, release_pulse_q;
  logic [7:0]  press_count_q, press_count_d;

  // btn_in is asynchronous; only btn_sync_q may be used by the FSM
  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q    <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sync1_q    <= btn_in;
      btn_sync_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= ST_RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RELEASED: begin
        if (btn_sync_q) state_d = ST_PRESS_CHK;
      end
      ST_PRESS_CHK: begin
        if (!btn_sync_q)             state_d = ST_RELEASED;
        else if (db_cnt_q == DB_LAST) state_d = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (!btn_sync_q) state_d = ST_RELEASE_CHK;
      end
      ST_RELEASE_CHK: begin
        if (btn_sync_q)               state_d = ST_PRESSED;
        else if (db_cnt_q == DB_LAST) state_d = ST_RELEASED;
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  // Transition strobes and debounce-counter controls; bounces produce none
  always_comb begin
    db_clr      = 1'b0;
    db_inc      = 1'b0;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (btn_sync_q) db_clr = 1'b1;
      end
      ST_PRESS_CHK: begin
        if (btn_sync_q) begin
          if (db_cnt_q == DB_LAST) press_evt = 1'b1;
          else                     db_inc    = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!btn_sync_q) db_clr = 1'b1;
      end
      ST_RELEASE_CHK: begin
        if (!btn_sync_q) begin
          if (db_cnt_q == DB_LAST) release_evt = 1'b1;
          else                     db_inc      = 1'b1;
        end
      end
      default: begin
        db_clr = 1'b0;
      end
    endcase
  end

  always_comb begin
    db_cnt_d = db_cnt_q;
    if (db_clr)      db_cnt_d = 16'd0;
    else if (db_inc) db_cnt_d = db_cnt_q + 16'd1;
  end

  always_comb begin
    btn_level_d = btn_level_q;
    if (press_evt)        btn_level_d = 1'b1;
    else if (release_evt) btn_level_d = 1'b0;
    press_count_d = press_count_q + {7'd0, press_evt};
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      db_cnt_q        <= 16'd0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      press_count_q   <= 8'h00;
    end else begin
      db_cnt_q        <= db_cnt_d;
      btn_level_q     <= btn_level_d;
      press_pulse_q   <= press_evt;
      release_pulse_q <= release_evt;
      press_count_q   <= press_count_d;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [15:0] HOLD_LAST = LONG_PRESS_CYCLES - 16'd1;

  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        long_done_q, long_done_d;
  logic        long_fire, long_fire_q, long_press_q;
  logic        in_hold;

  // Hold time keeps counting through release bounces; only a new press restarts it
  always_comb begin
    in_hold    = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_CHK);
    long_fire  = in_hold && (hold_cnt_q == HOLD_LAST) && !long_done_q;
    hold_cnt_d = hold_cnt_q;
    if (press_evt)                             hold_cnt_d = 16'd0;
    else if (in_hold && hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 16'd1;
    long_done_d = long_done_q;
    if (press_evt)      long_done_d = 1'b0;
    else if (long_fire) long_done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      hold_cnt_q   <= 16'd0;
      long_done_q  <= 1'b0;
      long_fire_q  <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_done_q  <= long_done_d;
      long_fire_q  <= long_fire;
      long_press_q <= long_fire_q;
    end
  end

  assign long_press = long_press_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_PRESS_CYCLES;
  assign long_press      = 1'b0;
`endif

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_count   = press_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: random and directed button waveforms compared every
// cycle against a run-length debounce model, plus directed latency/count checks.
module tb_button_debounce;

  localparam int DB = 4;
  localparam int LP = 10;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       btn_in = 1'b0;
  logic       btn_level, press_pulse, release_pulse, long_press;
  logic [7:0] press_count;
  logic [1:0] dbg_state;

  button_debounce #(
    .DEBOUNCE_CYCLES  (16'(DB)),
    .LONG_PRESS_CYCLES(16'(LP))
  ) dut (
    .clk          (clk),
    .srst         (srst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .press_count  (press_count),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected {level, press, release, long, count[7:0]} after each edge
  logic [11:0] exp_q[$];

  logic       hist_q[$];
  logic       m_lvl = 1'b0;
  int         m_run = 0;
  logic [7:0] m_cnt = 8'h00;
  int         m_held = 0;
  logic       m_done = 1'b0;
  logic       m_pend = 1'b0;

  int np, nr, nl, p_at, r_at, l_at;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // A level change is accepted once DB+1 consecutive synchronized samples
  // disagree with the current level; samples reach the FSM two edges late.
  task automatic model_edge(input logic b, input logic r);
    logic s, pp, rp, lp;
    pp = 1'b0;
    rp = 1'b0;
    lp = m_pend;
    m_pend = 1'b0;
    if (r) begin
      hist_q = '{1'b0, 1'b0};
      m_lvl  = 1'b0;
      m_run  = 0;
      m_cnt  = 8'h00;
      m_held = 0;
      m_done = 1'b0;
      lp     = 1'b0;
    end else begin
      s = hist_q.pop_front();
      hist_q.push_back(b);
      if (m_lvl) begin
        if (m_held < LP) m_held++;
        if (m_held == LP && !m_done) begin
          m_pend = 1'b1;
          m_done = 1'b1;
        end
      end
      if (s != m_lvl) m_run++;
      else            m_run = 0;
      if (m_run == DB + 1) begin
        m_lvl = s;
        m_run = 0;
        if (s) begin
          pp     = 1'b1;
          m_cnt  = m_cnt + 8'd1;
          m_held = 0;
          m_done = 1'b0;
        end else begin
          rp = 1'b1;
        end
      end
    end
`ifndef BUTTON_DEBOUNCE_LONG_PRESS_EN
    lp = 1'b0;
`endif
    exp_q.push_back({m_lvl, pp, rp, lp, m_cnt});
  endtask

  // Drive one cycle of inputs, advance the model, compare all outputs.
  task automatic cycle(input logic b, input logic r);
    logic [11:0] e;
    btn_in = b;
    srst   = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    e = exp_q.pop_front();
    check_eq("outputs", {4'd0, btn_level, press_pulse, release_pulse, long_press, press_count},
             {4'd0, e});
  endtask

  task automatic clr_stats();
    np = 0; nr = 0; nl = 0; p_at = -1; r_at = -1; l_at = -1;
  endtask

  task automatic tally(input int i);
    if (press_pulse)   begin np++; if (p_at < 0) p_at = i; end
    if (release_pulse) begin nr++; if (r_at < 0) r_at = i; end
    if (long_press)    begin nl++; if (l_at < 0) l_at = i; end
  endtask

  initial begin
    logic [7:0] cnt_before;
    int hi, lo, len;
    logic v, r;
    hist_q = '{1'b0, 1'b0};

    // reset held with the button down, then fresh press on exit
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      check_eq("reset_outs", {3'd0, btn_level, press_pulse, release_pulse, long_press, press_count, 1'b0}, 16'h0000);
    end
    clr_stats();
    for (int i = 1; i <= 20; i++) begin cycle(1'b1, 1'b0); tally(i); end
    check_eq("rst_exit_press_edge", 16'(p_at), 16'd7);
    check_eq("rst_exit_count", {8'd0, press_count}, 16'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);

    // clean press held 30 cycles, then release
    clr_stats();
    for (int i = 1; i <= 60; i++) begin cycle(i <= 30, 1'b0); tally(i); end
    check_eq("clean_press_edge", 16'(p_at), 16'd7);
    check_eq("clean_press_n", 16'(np), 16'd1);
    check_eq("clean_release_edge", 16'(r_at), 16'd37);
    check_eq("clean_release_n", 16'(nr), 16'd1);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    check_eq("long_press_n", 16'(nl), 16'd1);
    check_eq("long_press_gap", 16'(l_at - p_at), 16'(LP + 1));
`else
    check_eq("long_press_off_n", 16'(nl), 16'd0);
`endif

    // 1,1,1,0 bounce never accepted
    clr_stats();
    cnt_before = press_count;
    for (int k = 0; k < 20; k++)
      for (int j = 0; j < 4; j++) begin cycle(j != 3, 1'b0); tally(0); end
    for (int i = 0; i < 8; i++) begin cycle(1'b0, 1'b0); tally(0); end
    check_eq("bounce_press_n", 16'(np + nr), 16'd0);
    check_eq("bounce_level", {15'd0, btn_level}, 16'd0);
    check_eq("bounce_count", {8'd0, press_count}, {8'd0, cnt_before});

    // single-cycle low glitch while pressed
    clr_stats();
    for (int i = 0; i < 12; i++) begin cycle(1'b1, 1'b0); tally(0); end
    cycle(1'b0, 1'b0); tally(0);
    for (int i = 0; i < 12; i++) begin cycle(1'b1, 1'b0); tally(0); end
    check_eq("glitch_release_n", 16'(nr), 16'd0);
    check_eq("glitch_level", {15'd0, btn_level}, 16'd1);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);

    // shortest accepted pulse, released before the hold target
    clr_stats();
    for (int i = 1; i <= 30; i++) begin cycle(i <= DB + 1, 1'b0); tally(i); end
    check_eq("min_pulse_press_n", 16'(np), 16'd1);
    check_eq("min_pulse_release_n", 16'(nr), 16'd1);
    check_eq("short_hold_long_n", 16'(nl), 16'd0);

    // one cycle shorter is invisible
    clr_stats();
    for (int i = 1; i <= 25; i++) begin cycle(i <= DB, 1'b0); tally(i); end
    check_eq("short_pulse_n", 16'(np + nr + nl), 16'd0);

    // count wrap over 256 presses with random hold/gap lengths
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    for (int k = 0; k < 256; k++) begin
      hi = $urandom_range(DB + 1, DB + 4);
      lo = $urandom_range(DB + 1, DB + 4);
      for (int i = 0; i < hi; i++) cycle(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) cycle(1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
    check_eq("wrap_256", {8'd0, press_count}, 16'h0000);
    for (int i = 0; i < DB + 1; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);
    check_eq("wrap_257", {8'd0, press_count}, 16'h0001);

    // reset while pressed: no release pulse, count cleared, re-detected on exit
    for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0);
    check_eq("pre_reset_level", {15'd0, btn_level}, 16'd1);
    cycle(1'b1, 1'b1);
    check_eq("rst_pressed_level", {15'd0, btn_level}, 16'd0);
    check_eq("rst_pressed_count", {8'd0, press_count}, 16'd0);
    check_eq("rst_pressed_release", {15'd0, release_pulse}, 16'd0);
    clr_stats();
    for (int i = 1; i <= 15; i++) begin cycle(1'b1, 1'b0); tally(i); end
    check_eq("rst_pressed_exit_edge", 16'(p_at), 16'd7);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0);

    // random runs with occasional reset
    for (int k = 0; k < 400; k++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) begin
        r = ($urandom_range(0, 299) == 0);
        cycle(v, r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
